// File: rtl/mul_req_master_pkg.sv
// Shared constants for the multiplier request master: FSM encodings,
// LFSR tap mask, default seed and the LFSR next-state helper.
package mul_req_master_pkg;

  // FSM state encodings
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_ISSUE    = 3'd1;
  localparam logic [2:0] ST_WAIT_ACK = 3'd2;
  localparam logic [2:0] ST_GAP      = 3'd3;
  localparam logic [2:0] ST_DONE     = 3'd4;

  // Taps 32,22,2,1 -> bit positions 31,21,1,0
  localparam logic [31:0] LFSR_TAP_MASK     = 32'h8020_0003;
  localparam logic [31:0] LFSR_DEFAULT_SEED = 32'hACE1_2468;

  // Fibonacci form: shift left, feedback XOR of the tapped bits enters at bit 0
  function automatic logic [31:0] lfsr_next(input logic [31:0] v);
    return {v[30:0], ^(v & LFSR_TAP_MASK)};
  endfunction

endpackage

// File: rtl/mul_req_master_lfsr32.sv
// 32-bit LFSR; advances one step when step is high, reloads seed on reset.
module lfsr32
  import mul_req_master_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        step,
  input  logic [31:0] seed,
  output logic [31:0] value
);

  logic [31:0] value_q;

  // LFSR state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= seed;
    end else if (step) begin
      value_q <= lfsr_next(value_q);
    end
  end

  assign value = value_q;

endmodule

// File: rtl/mul_req_master.sv
// Request master for the sequential multiplier: issues {op1,op2} over the
// req/ack handshake, checks every returned product, counts requests and
// mismatches and aborts the run when the slave stops answering.
module mul_req_master
  import mul_req_master_pkg::*;
#(
  parameter int          OP_WIDTH      = 8,
  parameter int          ACKDATA_WIDTH = 16,
  parameter int          NUM_REQ       = 16,
  parameter int          START_LEN     = 2,
  parameter int          IMEDIAT       = 1,
  parameter int          DISPERSION    = 10,
  parameter int          TIMEOUT       = 255,
  parameter logic [31:0] LFSR_SEED     = LFSR_DEFAULT_SEED
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     op_mode,
  input  logic [OP_WIDTH-1:0]      fix_op1,
  input  logic [OP_WIDTH-1:0]      fix_op2,
  output logic                     req,
  output logic                     start,
  output logic [2*OP_WIDTH-1:0]    req_data,
  input  logic                     ack,
  input  logic [ACKDATA_WIDTH-1:0] ack_data,
  output logic [15:0]              req_cnt,
  output logic [15:0]              err_cnt,
  output logic                     timeout,
  output logic                     done
);

  localparam int          RW           = 2 * OP_WIDTH;
  localparam logic [15:0] START_LEN_C  = 16'(START_LEN);
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);
  localparam logic [15:0] NUM_REQ_C    = 16'(NUM_REQ);
  // Guard the modulo against a zero range when the gap path is unused
  localparam int          DISP_SAFE    = (DISPERSION < 1) ? 1 : DISPERSION;

  logic [2:0]               state_q, state_d;
  logic                     req_q, req_d, start_q, start_d;
  logic                     done_q, done_d, timeout_q, timeout_d;
  logic [RW-1:0]            req_data_q, req_data_d;
  logic [ACKDATA_WIDTH-1:0] exp_q, exp_d;
  logic [15:0]              req_cnt_q, req_cnt_d, err_cnt_q, err_cnt_d;
  logic [15:0]              start_cnt_q, start_cnt_d, tmo_cnt_q, tmo_cnt_d;
  logic [7:0]               gap_cnt_q, gap_cnt_d;

  logic                     lfsr_step, do_issue, last_req;
  logic [31:0]              lfsr_val;
  logic [OP_WIDTH-1:0]      op1_nx, op2_nx;
  logic [RW-1:0]            prod_nx;
  logic [7:0]               gap_draw;
  logic [15:0]              req_cnt_inc;
  logic                     unused_bits;

  lfsr32 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .step  (lfsr_step),
    .seed  (LFSR_SEED),
    .value (lfsr_val)
  );

  // Next operand pair, its full-width product and the gap drawn from the LFSR
  always_comb begin
    op1_nx   = op_mode ? fix_op1 : lfsr_val[RW-1:OP_WIDTH];
    op2_nx   = op_mode ? fix_op2 : lfsr_val[OP_WIDTH-1:0];
    prod_nx  = RW'(op1_nx) * RW'(op2_nx);
    gap_draw = 8'(32'(lfsr_val[7:0]) % DISP_SAFE);
  end

  assign unused_bits = ^{lfsr_val, prod_nx};

  // Handshake FSM, counters and product compare
  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    start_d     = start_q;
    done_d      = done_q;
    timeout_d   = timeout_q;
    req_data_d  = req_data_q;
    exp_d       = exp_q;
    req_cnt_d   = req_cnt_q;
    err_cnt_d   = err_cnt_q;
    start_cnt_d = start_cnt_q;
    tmo_cnt_d   = tmo_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    lfsr_step   = 1'b0;
    do_issue    = 1'b0;
    req_cnt_inc = req_cnt_q + 16'd1;
    last_req    = (NUM_REQ != 0) && (req_cnt_inc == NUM_REQ_C);

    case (state_q)
      ST_IDLE: begin
        if (en) begin
          req_cnt_d = '0;
          err_cnt_d = '0;
          timeout_d = 1'b0;
          do_issue  = 1'b1;
        end
      end
      ST_ISSUE, ST_WAIT_ACK: begin
        if (ack) begin
          req_cnt_d = req_cnt_inc;
          if ((ack_data != exp_q) && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
          end
          if (last_req) begin
            req_d   = 1'b0;
            start_d = 1'b0;
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else if (!en) begin
            req_d   = 1'b0;
            start_d = 1'b0;
            state_d = ST_IDLE;
          end else if ((IMEDIAT != 0) || (gap_draw == 8'd0)) begin
            do_issue = 1'b1;
          end else begin
            req_d      = 1'b0;
            start_d    = 1'b0;
            req_data_d = '0;
            gap_cnt_d  = gap_draw;
            state_d    = ST_GAP;
          end
        end else if (tmo_cnt_q == TIMEOUT_LAST) begin
          timeout_d = 1'b1;
          req_d     = 1'b0;
          start_d   = 1'b0;
          done_d    = 1'b1;
          state_d   = ST_DONE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 16'd1;
          if (state_q == ST_ISSUE) begin
            if (start_cnt_q == START_LEN_C) begin
              start_d = 1'b0;
              state_d = ST_WAIT_ACK;
            end else begin
              start_cnt_d = start_cnt_q + 16'd1;
            end
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == 8'd1) begin
          do_issue = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q - 8'd1;
        end
      end
      ST_DONE: begin
        if (!en) begin
          done_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Common request launch: operands and expected product are captured together
    if (do_issue) begin
      req_d       = 1'b1;
      start_d     = 1'b1;
      req_data_d  = {op1_nx, op2_nx};
      exp_d       = prod_nx[ACKDATA_WIDTH-1:0];
      start_cnt_d = 16'd1;
      tmo_cnt_d   = '0;
      lfsr_step   = 1'b1;
      state_d     = ST_ISSUE;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      req_q       <= 1'b0;
      start_q     <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
      req_data_q  <= '0;
      exp_q       <= '0;
      req_cnt_q   <= '0;
      err_cnt_q   <= '0;
      start_cnt_q <= '0;
      tmo_cnt_q   <= '0;
      gap_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      start_q     <= start_d;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
      req_data_q  <= req_data_d;
      exp_q       <= exp_d;
      req_cnt_q   <= req_cnt_d;
      err_cnt_q   <= err_cnt_d;
      start_cnt_q <= start_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
    end
  end

  assign req      = req_q;
  assign start    = start_q;
  assign done     = done_q;
  assign timeout  = timeout_q;
  assign req_data = req_data_q;
  assign req_cnt  = req_cnt_q;
  assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_mul_req_master.sv
// Bench for mul_req_master: two instances (back-to-back and random-gap),
// a reactive slave, an LFSR reference model and a request scoreboard.
module tb_mul_req_master;

  localparam int          OPW       = 8;
  localparam int          ADW       = 16;
  localparam int          NUM_REQ_A = 4;
  localparam logic [31:0] SEED      = 32'hACE1_2468;

  typedef struct packed {
    logic [15:0] rdata;
    logic [15:0] prod;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n, en_a, en_b, op_mode, ack, sel;
  logic [OPW-1:0] fix_op1, fix_op2;
  logic [ADW-1:0] ack_data;
  logic           a_req, a_start, a_timeout, a_done, b_req, b_start, b_timeout, b_done;
  logic [15:0]    a_rdata, b_rdata, a_rcnt, b_rcnt, a_ecnt, b_ecnt;
  logic           o_req, o_start, o_done, o_timeout;
  logic [15:0]    o_rdata, o_rcnt, o_ecnt;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] mdl [2];
  exp_t        sb[$];

  mul_req_master #(.OP_WIDTH(OPW), .ACKDATA_WIDTH(ADW), .NUM_REQ(NUM_REQ_A), .START_LEN(2),
                   .IMEDIAT(1), .DISPERSION(10), .TIMEOUT(255), .LFSR_SEED(SEED)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en_a), .op_mode(op_mode), .fix_op1(fix_op1), .fix_op2(fix_op2),
    .req(a_req), .start(a_start), .req_data(a_rdata), .ack(ack), .ack_data(ack_data),
    .req_cnt(a_rcnt), .err_cnt(a_ecnt), .timeout(a_timeout), .done(a_done));

  mul_req_master #(.OP_WIDTH(OPW), .ACKDATA_WIDTH(ADW), .NUM_REQ(0), .START_LEN(2),
                   .IMEDIAT(0), .DISPERSION(10), .TIMEOUT(255), .LFSR_SEED(SEED)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en_b), .op_mode(op_mode), .fix_op1(fix_op1), .fix_op2(fix_op2),
    .req(b_req), .start(b_start), .req_data(b_rdata), .ack(ack), .ack_data(ack_data),
    .req_cnt(b_rcnt), .err_cnt(b_ecnt), .timeout(b_timeout), .done(b_done));

  assign o_req     = sel ? b_req     : a_req;
  assign o_start   = sel ? b_start   : a_start;
  assign o_done    = sel ? b_done    : a_done;
  assign o_timeout = sel ? b_timeout : a_timeout;
  assign o_rdata   = sel ? b_rdata   : a_rdata;
  assign o_rcnt    = sel ? b_rcnt    : a_rcnt;
  assign o_ecnt    = sel ? b_ecnt    : a_ecnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference LFSR: taps 32,22,2,1, feedback shifted in at bit 0
  function automatic logic [31:0] mdl_step(input logic [31:0] v);
    return {v[30:0], v[31] ^ v[21] ^ v[1] ^ v[0]};
  endfunction

  task automatic set_en(input logic v);
    if (sel) en_b = v;
    else     en_a = v;
  endtask

  // Predict the next issued request and push it to the scoreboard
  task automatic push_next();
    exp_t     e;
    logic [7:0] o1, o2;
    o1 = op_mode ? fix_op1 : mdl[sel][15:8];
    o2 = op_mode ? fix_op2 : mdl[sel][7:0];
    e.rdata = {o1, o2};
    e.prod  = 16'(o1) * 16'(o2);
    sb.push_back(e);
    mdl[sel] = mdl_step(mdl[sel]);
  endtask

  task automatic start_run();
    set_en(1'b1);
    push_next();
  endtask

  // Slave: acks 3 cycles after each start rise; checks req_data, start length and gaps
  task automatic serve(input int n_ack, input bit corrupt, input bit drop_en);
    int          acks = 0, cd = -1, gap_exp = -1, gap_seen = 0, slen = 0, cyc = 0, n_iss = 0;
    bit          prev_start = 1'b0;
    bit          cont;
    logic [15:0] prod = '0, rd = '0;
    exp_t        e;
    while (acks < n_ack && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      ack = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 1 && drop_en && acks == n_ack - 1) set_en(1'b0);
        if (cd == 0) begin
          check("req_held_until_ack", o_req, 1);
          ack      = 1'b1;
          ack_data = corrupt ? (prod ^ 16'h0001) : prod;
          acks++;
          $display("txn %0d dut=%s req_data=0x%h ack_data=0x%h", acks, sel ? "b" : "a", rd, ack_data);
          cont = !(sel == 1'b0 && acks == NUM_REQ_A) && !(drop_en && acks == n_ack);
          if (cont) begin
            gap_exp = sel ? (int'(mdl[sel][7:0]) % 10) : 0;
            push_next();
          end
          cd = -1;
        end
      end
      if (o_start && !prev_start) begin
        n_iss++;
        if (n_iss == 1) check("issue_latency", cyc, 1);
        if (sb.size() == 0) begin
          check("scoreboard_empty", 1, 0);
        end else begin
          e    = sb.pop_front();
          rd   = e.rdata;
          prod = e.prod;
          check("req_data", o_rdata, e.rdata);
        end
        if (gap_exp >= 0) check("gap_len", gap_seen, gap_exp);
        gap_exp  = -1;
        gap_seen = 0;
        slen     = 0;
        cd       = 3;
      end
      if (o_start) slen++;
      else if (prev_start) check("start_len", slen, 2);
      if (!o_req && gap_exp >= 0) begin
        gap_seen++;
        check("gap_req_data_zero", o_rdata, 0);
      end
      prev_start = o_start;
    end
    if (acks < n_ack) check("serve_budget", acks, n_ack);
    @(negedge clk);
    ack = 1'b0;
  endtask

  initial begin
    exp_t e;
    int   hi;
    rst_n = 1'b0; en_a = 1'b0; en_b = 1'b0; op_mode = 1'b1; ack = 1'b0; ack_data = '0;
    fix_op1 = 8'd7; fix_op2 = 8'd10; sel = 1'b0;
    mdl[0] = SEED; mdl[1] = SEED;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      check("rst_flags", {o_req, o_start, o_done, o_timeout}, 0);
      check("rst_req_data", o_rdata, 0);
      check("rst_counters", {o_rcnt, o_ecnt}, 0);
    end
    sel = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: fixed operands 7*10, correct products, run of NUM_REQ_A
    start_run();
    serve(NUM_REQ_A, 1'b0, 1'b0);
    check("t1_req_low", o_req, 0);
    check("t1_done", o_done, 1);
    check("t1_req_cnt", o_rcnt, NUM_REQ_A);
    check("t1_err_cnt", o_ecnt, 0);
    ack = 1'b1; ack_data = 16'h0046;
    @(negedge clk);
    ack = 1'b0;
    check("t1_ack_in_done_ignored", o_rcnt, NUM_REQ_A);
    check("t1_done_held", o_done, 1);
    set_en(1'b0);
    @(negedge clk);
    check("t1_done_cleared", o_done, 0);

    // 2: slave returns 0x0047 for every request
    start_run();
    serve(NUM_REQ_A, 1'b1, 1'b0);
    check("t2_err_cnt", o_ecnt, NUM_REQ_A);
    check("t2_done", o_done, 1);
    set_en(1'b0);
    @(negedge clk);

    // 3: LFSR operands, back-to-back
    op_mode = 1'b0;
    start_run();
    serve(NUM_REQ_A, 1'b0, 1'b0);
    check("t3_req_cnt", o_rcnt, NUM_REQ_A);
    check("t3_err_cnt", o_ecnt, 0);
    check("t3_done", o_done, 1);
    set_en(1'b0);
    @(negedge clk);

    // 5: silent slave -> timeout
    start_run();
    @(negedge clk);
    e = sb.pop_front();
    check("t5_req_data", o_rdata, e.rdata);
    hi = 0;
    while (o_req && hi < 400) begin
      hi++;
      @(negedge clk);
    end
    check("t5_req_high_cycles", hi, 255);
    check("t5_timeout", o_timeout, 1);
    check("t5_done", o_done, 1);
    check("t5_start_low", o_start, 0);
    check("t5_req_cnt", o_rcnt, 0);
    set_en(1'b0);
    @(negedge clk);
    check("t5_timeout_sticky", o_timeout, 1);
    check("t5_done_cleared", o_done, 0);

    // 6a: asynchronous reset in WAIT_ACK
    start_run();
    repeat (4) @(negedge clk);
    check("t6_timeout_cleared", o_timeout, 0);
    check("t6_in_wait_ack", {o_req, o_start}, 2'b10);
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_rst_flags", {o_req, o_start, o_done}, 0);
    check("t6_async_rst_data", o_rdata, 0);
    en_a = 1'b0;
    sb.delete();
    mdl[0] = SEED; mdl[1] = SEED;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_run();
    serve(NUM_REQ_A, 1'b0, 1'b0);
    check("t6_recover_req_cnt", o_rcnt, NUM_REQ_A);
    check("t6_recover_done", o_done, 1);
    set_en(1'b0);
    @(negedge clk);

    // 4 + 6b: random gaps, en dropped during the last WAIT_ACK
    sel = 1'b1;
    #1;
    start_run();
    serve(8, 1'b0, 1'b1);
    check("t4_req_low_after_drop", o_req, 0);
    check("t4_done_not_set", o_done, 0);
    check("t4_req_cnt", o_rcnt, 8);
    check("t4_err_cnt", o_ecnt, 0);
    @(negedge clk);
    start_run();
    serve(2, 1'b0, 1'b1);
    check("t4_rerun_req_cnt", o_rcnt, 2);
    check("t4_rerun_req_low", o_req, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
